op_sequencer: RTL and testbench
===============================

// Module: op_sequencer
// PURPOSE
//  Command scheduler in front of the matrix-multiply controller. Queues 32-bit operation
//  words from the host and drives the controller's operation/in_data/enable inputs.
//  Multiplies (op 1) are held for a fixed window. Serial page loads (op 2) stream one
//  data word per accepted host beat. Idle gaps are inserted so the controller's
//  opcode-1 rising-edge detect re-arms between commands.
// PARAMETERS
//  QDEPTH      4   command FIFO depth, power of 2, >=2
//  MULT_CYCLES 80  cycles a multiply opcode is held on operation (stream + array drain)
//  WLOAD_LEN   32  data words per W-page load (op_a[3]==1)
//  XLOAD_LEN   80  data words per X-page load (op_a[3]==0)
//  GAP_CYCLES  1   state cycles with operation==0 after every op-1/op-2 command, >=1
// PORTS
//  clk         in   1   clock
//  reset       in   1   asynchronous, active-low reset
//  cmd_valid   in   1   host command valid
//  cmd_ready   out  1   FIFO not full; push when cmd_valid&&cmd_ready
//  cmd_op      in   32  operation word; [3:0] opcode, [7:4] op_a, [11:8] op_b, [15:12] op_c
//  dat_valid   in   1   host load-data valid
//  dat_ready   out  1   high only in LOAD state
//  dat_data    in   32  load data word
//  pause       in   1   freeze sequencer and controller
//  flush       in   1   drop all queued (not in-flight) commands
//  operation   out  32  to controller operation, registered
//  in_data     out  32  to controller in_data, registered
//  ctl_enable  out  1   to controller enable
//  ctl_reset   out  1   to controller reset (sync, active-high)
//  busy        out  1   state!=IDLE or FIFO non-empty
//  done        out  1   1-cycle pulse on the first GAP cycle of each op-1/op-2 command
//  err         out  1   sticky: unknown opcode popped; cleared only by reset
//  q_count     out  clog2(QDEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (async, reset==0):
//   - operation=0, in_data=0, ctl_enable=0, ctl_reset=1, done=0, err=0, FIFO empty,
//     state=IDLE.
//   - Reset mid-command aborts it immediately. No partial state survives.
//  ctl_reset: stays 1 for 2 clk edges after reset deasserts (2-flop synchroniser),
//   then 0. Sequencer stays in IDLE, cmd_ready=0, while ctl_reset==1.
//  ctl_enable: = !pause && !ctl_reset.
//  pause==1: state, counters, FIFO pop, dat_ready and operation/in_data all frozen.
//   FIFO push is still allowed.
//  FIFO:
//   - Push when cmd_valid&&cmd_ready. Pop only in IDLE when non-empty.
//   - Push and pop in the same cycle is legal; q_count is unchanged.
//   - Full: cmd_ready=0. flush has priority over push/pop: q_count=0 next cycle; the
//     current command still completes.
//  FSM (one state per clk while !pause):
//   IDLE: if FIFO non-empty, pop head into cur_op and decode:
//     - opcode 1: go to MULT, cnt=MULT_CYCLES.
//     - opcode 2: go to LOAD, cnt = op_a[3] ? WLOAD_LEN : XLOAD_LEN.
//     - opcode 0: discarded; stay in IDLE. No done.
//     - other: discarded, err<=1; stay in IDLE.
//   MULT: cnt-- each cycle. When cnt reaches 1, go to GAP (cnt=GAP_CYCLES).
//   LOAD: dat_ready=1. Accept = dat_valid. Each accept decrements cnt; no accept holds.
//     Last accept goes to GAP.
//   GAP: done=1 in the first cycle. cnt-- each cycle. When cnt reaches 1, go to IDLE.
//  Output register (1-cycle latency from state cycle):
//   - next operation = cur_op if MULT, or if LOAD && accept; otherwise 32'h0.
//   - next in_data = dat_data on accept; otherwise hold.
//   - operation is therefore cur_op for exactly MULT_CYCLES consecutive cycles per
//     multiply.
//   - Between any two commands operation==0 for >= GAP_CYCLES+1 cycles (GAP + IDLE).
//  Load stall: cycles without an accept produce operation==0, so the controller writes
//   nothing.
//  Counters: cnt is 9 bits wide; the parameters must be <=511.
// TESTING
//  T1 reset:
//   - Hold reset=0 for 3 cycles, then release.
//   - Expect ctl_reset=1 for 2 further edges, then 0; operation=0; cmd_ready=1;
//     q_count=0; err=0.
//  T2 single multiply:
//   - Push 32'h0000_0081 (x pg1, w pg0).
//   - Expect operation=32'h81 for exactly 80 consecutive cycles, then 0, done pulse
//     once, busy then low.
//  T3 X load with stalls:
//   - Push 32'h0000_0012. Drive dat_valid with pattern 1,0,1,... Data values 1..80.
//   - Expect exactly 80 cycles of operation=32'h12 with in_data 1..80 in order; 0 on
//     stall cycles; dat_ready drops after the 80th accept.
//  T4 back-to-back:
//   - Push two multiplies in consecutive cycles.
//   - Expect two 80-cycle windows separated by >=2 cycles of operation==0; two done
//     pulses; q_count peak=2.
//  T5 queue full / flush / bad opcode:
//   - Pause, push 5 commands. Expect cmd_ready=0 after 4, q_count=4.
//   - Flush. Expect q_count=0.
//   - Push 32'h7. Expect err=1, no done, operation stays 0.
//  T6 pause and reset mid-op:
//   - pause=1 for 10 cycles mid-MULT. Expect ctl_enable=0 and operation held; window
//     still totals 80 active cycles.
//   - Reset during a load. Expect all outputs at reset values immediately.

Source files
------------

// File: rtl/op_sequencer_if.sv
// Host-side handshake bundle for op_sequencer.
//   cmd_valid/cmd_ready/cmd_op    : command push channel (32-bit operation word)
//   dat_valid/dat_ready/dat_data  : serial page-load data channel
// master = host driving commands/data, slave = sequencer.
interface op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op;
  logic        dat_valid;
  logic        dat_ready;
  logic [31:0] dat_data;

  modport master (
    output cmd_valid, cmd_op, dat_valid, dat_data,
    input  cmd_ready, dat_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, dat_valid, dat_data,
    output cmd_ready, dat_ready
  );
endinterface

// File: rtl/op_sequencer.sv
// Command scheduler in front of the matrix-multiply controller.
// Queues host operation words in a small FIFO and drives the controller's
// operation/in_data/enable/reset inputs. Multiplies hold their opcode for
// MULT_CYCLES, page loads forward one data word per accepted beat, and every
// op-1/op-2 command is followed by GAP_CYCLES of operation==0 so the
// controller's opcode rising-edge detect re-arms.
// Ports:
//   clk, reset (async, active-low)
//   host       : op_sequencer_if.slave (cmd_* push channel, dat_* load channel)
//   pause      : freeze sequencer and controller (FIFO push still allowed)
//   flush      : drop all queued commands (in-flight command completes)
//   operation, in_data : registered controller inputs
//   ctl_enable, ctl_reset : controller enable / synchronous reset
//   busy, done, err, q_count : status
module op_sequencer #(
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned MULT_CYCLES = 80,
  parameter int unsigned WLOAD_LEN   = 32,
  parameter int unsigned XLOAD_LEN   = 80,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  op_sequencer_if.slave             host,
  input  logic                      pause,
  input  logic                      flush,
  output logic [31:0]               operation,
  output logic [31:0]               in_data,
  output logic                      ctl_enable,
  output logic                      ctl_reset,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(QDEPTH):0]   q_count
);
  localparam int unsigned AW = $clog2(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_LOAD, S_GAP} state_t;

  state_t        r_state;
  logic [8:0]    r_cnt;
  logic [31:0]   r_cur_op;
  logic [31:0]   r_operation;
  logic [31:0]   r_in_data;
  logic          r_done;
  logic          r_err;
  logic          r_sync1;
  logic          r_sync2;

  logic [31:0]   r_mem [QDEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          w_run;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_accept;
  logic [31:0]   w_head;

  // Sequencer only advances when not paused and the controller is out of reset.
  assign w_run   = !pause && !r_sync2;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(QDEPTH));
  assign w_head  = r_mem[r_rptr];

  assign host.cmd_ready = !w_full && !r_sync2;
  // flush wins over both FIFO operations.
  assign w_push = host.cmd_valid && host.cmd_ready && !flush;
  assign w_pop  = (r_state == S_IDLE) && w_run && !w_empty && !flush;

  // dat_ready is gated by pause so a frozen LOAD never advertises a beat it
  // would not take.
  assign host.dat_ready = (r_state == S_LOAD) && w_run;
  assign w_accept       = host.dat_ready && host.dat_valid;

  assign operation  = r_operation;
  assign in_data    = r_in_data;
  assign ctl_reset  = r_sync2;
  assign ctl_enable = !pause && !r_sync2;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign done       = r_done;
  assign err        = r_err;
  assign q_count    = r_count;

  // Controller reset: held for two edges after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= 1'b0;
      r_sync2 <= r_sync1;
    end
  end

  // Command FIFO pointers/occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= host.cmd_op;
  end

  // Sequencer FSM with registered controller outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cur_op    <= '0;
      r_operation <= '0;
      r_in_data   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_run) begin
        r_operation <= '0;
        case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              r_cur_op <= w_head;
              case (w_head[3:0])
                4'd0: r_state <= S_IDLE;
                4'd1: begin
                  r_state <= S_MULT;
                  r_cnt   <= 9'(MULT_CYCLES);
                end
                4'd2: begin
                  r_state <= S_LOAD;
                  r_cnt   <= w_head[7] ? 9'(WLOAD_LEN) : 9'(XLOAD_LEN);
                end
                default: r_err <= 1'b1;
              endcase
            end
          end
          S_MULT: begin
            r_operation <= r_cur_op;
            if (r_cnt == 9'd1) begin
              r_state <= S_GAP;
              r_cnt   <= 9'(GAP_CYCLES);
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_LOAD: begin
            if (w_accept) begin
              r_operation <= r_cur_op;
              r_in_data   <= host.dat_data;
              if (r_cnt == 9'd1) begin
                r_state <= S_GAP;
                r_cnt   <= 9'(GAP_CYCLES);
                r_done  <= 1'b1;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
          end
          S_GAP: begin
            if (r_cnt == 9'd1) r_state <= S_IDLE;
            else               r_cnt   <= r_cnt - 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer.
// A schedule-of-slots model predicts every output each cycle; directed
// scenarios add hand-computed literal checks on windows, data order, queue
// occupancy, error and reset behaviour.
module tb_op_sequencer;
  localparam int QD = 4;
  localparam int MC = 80;
  localparam int WL = 32;
  localparam int XL = 80;
  localparam int GC = 1;

  logic        clk;
  logic        reset;
  logic        pause;
  logic        flush;
  logic [31:0] operation;
  logic [31:0] in_data;
  logic        ctl_enable;
  logic        ctl_reset;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  q_count;

  op_sequencer_if hif();

  op_sequencer #(
    .QDEPTH(QD), .MULT_CYCLES(MC), .WLOAD_LEN(WL), .XLOAD_LEN(XL), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .reset(reset), .host(hif), .pause(pause), .flush(flush),
    .operation(operation), .in_data(in_data), .ctl_enable(ctl_enable),
    .ctl_reset(ctl_reset), .busy(busy), .done(done), .err(err), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each popped command expands into a list of per-cycle slots:
  //   ACT  = drive the opcode, BEAT = one load word (consumed only on accept),
  //   GAPF/GAP = operation 0 (GAPF raises done). Empty list = idle.
  localparam logic [1:0] K_ACT = 2'd0, K_BEAT = 2'd1, K_GAPF = 2'd2, K_GAP = 2'd3;
  typedef struct packed { logic [1:0] kind; logic [31:0] val; } slot_t;

  function automatic slot_t mk(input logic [1:0] k, input logic [31:0] v);
    slot_t s;
    s.kind = k;
    s.val  = v;
    return s;
  endfunction

  slot_t       sched[$];
  logic [31:0] mq[$];
  int          m_rs;
  logic [31:0] m_op, m_data, n_op, c;
  bit          m_done, m_err, n_done, took, rdy;
  int          rs_pre;
  slot_t       h;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sched.delete(); mq.delete();
      m_rs = 2; m_op = '0; m_data = '0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      rdy    = (mq.size() < QD) && (m_rs == 0);
      rs_pre = m_rs;
      if (m_rs > 0) m_rs--;
      if (!pause) begin
        n_op = '0; n_done = 1'b0;
        if (sched.size() > 0) begin
          h = sched[0]; took = 1'b0;
          if (h.kind == K_BEAT) begin
            if (hif.dat_valid) begin n_op = h.val; m_data = hif.dat_data; took = 1'b1; end
          end else begin
            if (h.kind == K_ACT) n_op = h.val;
            took = 1'b1;
          end
          if (took) void'(sched.pop_front());
          if (took && (h.kind == K_ACT || h.kind == K_BEAT) && sched.size() > 0 && sched[0].kind == K_GAPF)
            n_done = 1'b1;
        end else if (rs_pre == 0 && mq.size() > 0 && !flush) begin
          c = mq.pop_front();
          case (c[3:0])
            4'd0: ;
            4'd1, 4'd2: begin
              if (c[3:0] == 4'd1) for (int i = 0; i < MC; i++) sched.push_back(mk(K_ACT, c));
              else for (int i = 0; i < (c[7] ? WL : XL); i++) sched.push_back(mk(K_BEAT, c));
              sched.push_back(mk(K_GAPF, '0));
              for (int i = 1; i < GC; i++) sched.push_back(mk(K_GAP, '0));
            end
            default: m_err = 1'b1;
          endcase
        end
        m_op = n_op; m_done = n_done;
      end else begin
        m_done = 1'b0;
      end
      if (flush) mq.delete();
      else if (hif.cmd_valid && rdy) mq.push_back(hif.cmd_op);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("operation",  operation,           m_op);
      chk("in_data",    in_data,             m_data);
      chk("done",       32'(done),           32'(m_done));
      chk("err",        32'(err),            32'(m_err));
      chk("q_count",    32'(q_count),        32'(mq.size()));
      chk("busy",       32'(busy),           32'(sched.size() > 0 || mq.size() > 0));
      chk("cmd_ready",  32'(hif.cmd_ready),  32'(mq.size() < QD && m_rs == 0));
      chk("dat_ready",  32'(hif.dat_ready),
          32'(sched.size() > 0 && sched[0].kind == K_BEAT && !pause && m_rs == 0));
      chk("ctl_reset",  32'(ctl_reset),      32'(m_rs > 0));
      chk("ctl_enable", 32'(ctl_enable),     32'(!pause && m_rs == 0));
    end
  end

  // ---------------- scenario trackers ----------------
  int          act_by[logic [31:0]];
  int          done_cnt, peak_q, nz_cnt, run, max_run, zrun, min_gap, d_idx, d_bad;
  logic [31:0] run_val, last_nz;
  bit          seen_nz;

  task automatic clr();
    act_by.delete();
    done_cnt = 0; peak_q = 0; nz_cnt = 0; run = 0; max_run = 0; zrun = 0;
    min_gap = 1000; d_idx = 0; d_bad = 0; run_val = '0; last_nz = '0; seen_nz = 1'b0;
  endtask

  function automatic int act_of(input logic [31:0] v);
    return act_by.exists(v) ? act_by[v] : 0;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      if (done) done_cnt++;
      if (int'(q_count) > peak_q) peak_q = int'(q_count);
      if (operation != '0) nz_cnt++;
      if (ctl_enable) begin
        if (operation != '0) begin
          act_by[operation] = act_of(operation) + 1;
          run = (operation == run_val) ? run + 1 : 1;
          run_val = operation;
          if (run > max_run) max_run = run;
          if (seen_nz && operation != last_nz && zrun < min_gap) min_gap = zrun;
          last_nz = operation; seen_nz = 1'b1; zrun = 0;
          if (operation == 32'h12) begin
            if (in_data != 32'(d_idx + 1)) d_bad++;
            d_idx++;
          end
        end else begin
          run = 0; run_val = '0; zrun++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] op);
    hif.cmd_valid = 1'b1;
    hif.cmd_op    = op;
    step();
    hif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    i = 0;
    while (busy && i < budget) begin step(); i++; end
    if (busy) begin
      vec++; miss++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", nm, budget);
    end
    step(); step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss + 1);
    $fatal(1, "watchdog");
  end

  int  k;
  bit  tgl, acc;

  initial begin
    reset = 1'b1; pause = 1'b0; flush = 1'b0;
    hif.cmd_valid = 1'b0; hif.cmd_op = '0; hif.dat_valid = 1'b0; hif.dat_data = '0;
    clr();
    #2 reset = 1'b0;
    #1 checking = 1'b1;

    // T1 reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("t1_ctl_reset_rel", 32'(ctl_reset), 32'd1);
    step();
    chk("t1_ctl_reset_e1", 32'(ctl_reset), 32'd1);
    chk("t1_cmd_ready_e1", 32'(hif.cmd_ready), 32'd0);
    step();
    chk("t1_ctl_reset_e2", 32'(ctl_reset), 32'd0);
    chk("t1_cmd_ready",    32'(hif.cmd_ready), 32'd1);
    chk("t1_q_count",      32'(q_count), 32'd0);
    chk("t1_err",          32'(err), 32'd0);
    chk("t1_operation",    operation, 32'h0);

    // T2 single multiply
    clr();
    push(32'h0000_0081);
    wait_idle(200, "t2_idle");
    chk("t2_active_cycles", 32'(act_of(32'h81)), 32'd80);
    chk("t2_contiguous",    32'(max_run), 32'd80);
    chk("t2_done_pulses",   32'(done_cnt), 32'd1);
    chk("t2_busy",          32'(busy), 32'd0);
    chk("t2_op_after",      operation, 32'h0);

    // T3 X load with stalls (79 beats), then T4 pushes two multiplies while
    // the last beat is withheld, then the final beat is delivered.
    clr();
    push(32'h0000_0012);
    k = 0; tgl = 1'b1;
    for (int i = 0; i < 400 && k < 79; i++) begin
      hif.dat_valid = tgl;
      hif.dat_data  = 32'(k + 1);
      acc = tgl && hif.dat_ready;
      step();
      if (acc) k++;
      tgl = !tgl;
    end
    hif.dat_valid = 1'b0;
    chk("t3_beats_79", 32'(k), 32'd79);
    chk("t3_dat_ready_hold", 32'(hif.dat_ready), 32'd1);
    push(32'h0000_0081);
    push(32'h0000_0041);
    chk("t4_q_two", 32'(q_count), 32'd2);
    hif.dat_valid = 1'b1;
    hif.dat_data  = 32'd80;
    for (int i = 0; i < 10 && k < 80; i++) begin
      acc = hif.dat_ready;
      step();
      if (acc) k++;
    end
    hif.dat_valid = 1'b0;
    chk("t3_beats_80", 32'(k), 32'd80);
    chk("t3_dat_ready_drop", 32'(hif.dat_ready), 32'd0);
    wait_idle(400, "t4_idle");
    chk("t3_load_cycles", 32'(act_of(32'h12)), 32'd80);
    chk("t3_data_count",  32'(d_idx), 32'd80);
    chk("t3_data_order",  32'(d_bad), 32'd0);
    chk("t4_win_a",       32'(act_of(32'h81)), 32'd80);
    chk("t4_win_b",       32'(act_of(32'h41)), 32'd80);
    chk("t4_min_gap_ge2", 32'(min_gap >= 2), 32'd1);
    chk("t4_peak_q",      32'(peak_q), 32'd2);
    chk("t34_done_pulses", 32'(done_cnt), 32'd3);

    // T5 queue full / flush / bad opcode
    clr();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hif.cmd_valid = 1'b1;
      case (i)
        0: hif.cmd_op = 32'h81;
        1: hif.cmd_op = 32'h12;
        2: hif.cmd_op = 32'h00;
        3: hif.cmd_op = 32'h07;
        default: hif.cmd_op = 32'h41;
      endcase
      step();
    end
    hif.cmd_valid = 1'b0;
    chk("t5_q_full",     32'(q_count), 32'd4);
    chk("t5_cmd_ready",  32'(hif.cmd_ready), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_flush_q",    32'(q_count), 32'd0);
    chk("t5_flush_busy", 32'(busy), 32'd0);
    pause = 1'b0;
    push(32'h0000_0007);
    step(); step(); step();
    chk("t5_err",        32'(err), 32'd1);
    chk("t5_no_done",    32'(done_cnt), 32'd0);
    chk("t5_op_zero",    32'(nz_cnt), 32'd0);

    // T6 pause mid-multiply, then reset mid-load
    clr();
    push(32'h0000_0081);
    repeat (20) step();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_pause_enable", 32'(ctl_enable), 32'd0);
      chk("t6_pause_hold",   operation, 32'h81);
    end
    pause = 1'b0;
    wait_idle(200, "t6_idle");
    chk("t6_active_cycles", 32'(act_of(32'h81)), 32'd80);
    chk("t6_done_pulses",   32'(done_cnt), 32'd1);

    push(32'h0000_0082);
    hif.dat_valid = 1'b1;
    hif.dat_data  = 32'hA5A5_0001;
    repeat (5) step();
    chk("t6_in_load", 32'(hif.dat_ready), 32'd1);
    reset = 1'b0;
    hif.dat_valid = 1'b0;
    #1;
    chk("t6_rst_operation", operation, 32'h0);
    chk("t6_rst_in_data",   in_data, 32'h0);
    chk("t6_rst_ctl_reset", 32'(ctl_reset), 32'd1);
    chk("t6_rst_enable",    32'(ctl_enable), 32'd0);
    chk("t6_rst_done",      32'(done), 32'd0);
    chk("t6_rst_err",       32'(err), 32'd0);
    chk("t6_rst_q",         32'(q_count), 32'd0);
    chk("t6_rst_busy",      32'(busy), 32'd0);
    chk("t6_rst_dat_ready", 32'(hif.dat_ready), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    repeat (4) step();
    chk("t6_post_ctl_reset", 32'(ctl_reset), 32'd0);
    chk("t6_post_op",        operation, 32'h0);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
